// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM encoding and
// default widths / reset address.
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam logic [7:0]  RESET_PC_DEF   = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset, redirect load, increment or hold.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    // Redirect load wins over increment; increment wraps modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the ROM and presents the
// fetched word to decode over a valid/ready handshake.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  running
);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic                  load;
    logic [ADDR_WIDTH-1:0] pc;

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (load),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE:    state_nxt = halt ? HALTED : RUN;
            RUN: begin
                state_nxt = halt ? HALTED : RUN;
                // halt and redirect both block the load in the cycle they appear
                load = !halt && !redirect_valid && (!instr_valid || instr_ready);
            end
            HALTED:  state_nxt = halt ? HALTED : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Redirect flushes the held word even if decode is ready this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    assign rom_address = pc;
    assign running     = (state == RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a {8'hA5, address} ROM model
// and a scoreboard of expected instruction words.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_address;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic        running;

    int unsigned checks;
    int unsigned errors;
    logic [15:0] sb[$];

    fetch_unit #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (16),
        .RESET_PC   (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .running        (running)
    );

    assign rom_data = {8'hA5, rom_address};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_run(input logic [7:0] start, input int unsigned n);
        logic [7:0] a;
        a = start;
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back({8'hA5, a});
            a = a + 8'd1;
        end
    endtask

    // Compare at the falling edge any word decode will take on the next rising edge.
    task automatic tick();
        logic [15:0] exp;
        @(negedge clk);
        if (instr_valid && instr_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                check("instr", 32'(instr), 32'(exp));
                check("instr_pc", 32'(instr_pc), 32'(exp[7:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},    32'(rom_address), 32'h00);
        check({tag, "_instr"},   32'(instr),       32'h0);
        check({tag, "_ipc"},     32'(instr_pc),    32'h0);
        check({tag, "_valid"},   32'(instr_valid), 32'd0);
        check({tag, "_running"}, 32'(running),     32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        halt = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        instr_ready = 1'b1;
        push_run(8'h00, 4);

        // Startup: one IDLE cycle, then first load
        tick();
        check("startup_e1_valid", 32'(instr_valid), 32'd0);
        check("startup_e1_running", 32'(running), 32'd1);
        tick();
        check("startup_e2_valid", 32'(instr_valid), 32'd1);
        repeat (4) tick();

        // Backpressure on A504
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_instr", 32'(instr), 32'hA504);
            check("bp_ipc", 32'(instr_pc), 32'h04);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_pc", 32'(rom_address), 32'h05);
        end
        instr_ready = 1'b1;
        push_run(8'h04, 2);
        repeat (2) tick();

        // Redirect while A506 is valid and ready: A506 is discarded
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        check("redir_flush_valid", 32'(instr_valid), 32'd0);
        check("redir_pc", 32'(rom_address), 32'hFE);
        redirect_valid = 1'b0;
        push_run(8'hFE, 4);
        tick();
        check("redir_e2_valid", 32'(instr_valid), 32'd1);
        check("redir_e2_instr", 32'(instr), 32'hA5FE);
        repeat (3) tick();
        check("wrap_pc", 32'(rom_address), 32'h02);

        // Halt: pending A501 drains, then no more loads
        halt = 1'b1;
        tick();
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_running", 32'(running), 32'd0);
        check("halt_pc_hold", 32'(rom_address), 32'h02);
        tick();
        check("halted_valid", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        tick();
        check("halt_redir_pc", 32'(rom_address), 32'h40);
        check("halt_redir_running", 32'(running), 32'd0);
        redirect_valid = 1'b0;
        halt = 1'b0;
        push_run(8'h40, 2);
        tick();
        check("resume_running", 32'(running), 32'd1);
        check("resume_valid", 32'(instr_valid), 32'd0);
        tick();
        check("resume_instr", 32'(instr), 32'hA540);
        repeat (2) tick();

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        push_run(8'h00, 2);
        tick();
        check("restart_e1_valid", 32'(instr_valid), 32'd0);
        tick();
        check("restart_e2_instr", 32'(instr), 32'hA500);
        repeat (2) tick();
        instr_ready = 1'b0;
        tick();
        check("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, required finish before 20000");
        $fatal(1);
    end

endmodule
